memory_mmio: RTL and testbench

Parametrised data/instruction memory with a memory-mapped I/O decoder for the single-cycle/pipelined cores. It replaces the fixed 32K-word, UART-read-only memory block. It adds byte-lane writes, a UART status register, back-pressure (stall) on the UART TX and RX paths, a free-running cycle timer, and a synchronous reset. The block sits between the core's load/store and fetch ports, the dual-port RAM, the UART FIFOs and the 7-segment driver.

---
 rtl/memory_mmio.sv | 133 +++++++++++++
 tb/tb_memory_mmio.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_mmio.sv
// memory_mmio: dual-port data/instruction RAM behind a memory-mapped I/O decoder
// (7-segment register, UART data/status with back-pressure, cycle timer).
module memory_mmio #(
    parameter int RAM_AW      = 15,
    parameter int SEG_W       = 16,
    parameter bit BLOCKING_RX = 1'b0,
    parameter int TIMER_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr_inst,
    output logic [31:0]      readdata_inst,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byteen,
    input  logic             writectrl,
    input  logic             readctrl,
    output logic [31:0]      readdata,
    output logic             stall,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rx_rdreq,
    input  logic             tx_full,
    output logic [7:0]       tx_data,
    output logic             tx_wrreq,
    output logic [SEG_W-1:0] seg_io
);
    localparam logic [31:0] ADDR_SEG   = 32'h0000_0000;
    localparam logic [31:0] ADDR_UART  = 32'h0000_0004;
    localparam logic [31:0] ADDR_STAT  = 32'h0000_0008;
    localparam logic [31:0] ADDR_TIMER = 32'h0000_000C;

    typedef enum logic [2:0] {SEL_RAM, SEL_SEG, SEL_UART, SEL_STAT, SEL_TIMER} sel_e;

    logic w_is_seg, w_is_uart, w_is_stat, w_is_timer, w_is_ram;
    logic w_stall_raw, w_accept, w_wr, w_rd;
    logic [RAM_AW-1:0] w_daddr, w_iaddr;
    logic w_unused_inst;

    assign w_is_seg   = (addr == ADDR_SEG);
    assign w_is_uart  = (addr == ADDR_UART);
    assign w_is_stat  = (addr == ADDR_STAT);
    assign w_is_timer = (addr == ADDR_TIMER);
    assign w_is_ram   = ~(w_is_seg | w_is_uart | w_is_stat | w_is_timer);

    // Reset masks the FIFO handshakes so no push/pop escapes while the core restarts.
    assign w_stall_raw = (writectrl & w_is_uart & tx_full)
                       | (BLOCKING_RX & readctrl & w_is_uart & rx_empty);
    assign stall    = ~reset & w_stall_raw;
    assign w_accept = ~reset & (readctrl | writectrl) & ~w_stall_raw;
    assign w_wr     = w_accept & writectrl;
    assign w_rd     = w_accept & readctrl & ~writectrl;
    assign tx_wrreq = ~reset & writectrl & w_is_uart & ~tx_full;
    assign tx_data  = writedata[7:0];
    assign rx_rdreq = ~reset & readctrl & ~writectrl & w_is_uart & ~rx_empty;

    assign w_daddr       = addr[RAM_AW+1:2];
    assign w_iaddr       = addr_inst[RAM_AW+1:2];
    assign w_unused_inst = ^{addr_inst[31:RAM_AW+2], addr_inst[1:0]};

    logic [31:0] r_mem [2**RAM_AW];
    logic [31:0] r_ram_q, r_inst_q;

    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wr && w_is_ram && byteen[i])
                r_mem[w_daddr][8*i +: 8] <= writedata[8*i +: 8];
        end
        r_ram_q  <= r_mem[w_daddr];
        r_inst_q <= r_mem[w_iaddr];
    end

    assign readdata_inst = r_inst_q;

    logic [SEG_W-1:0]   r_seg;
    logic [TIMER_W-1:0] r_timer, r_timer_q;
    sel_e               r_sel;
    logic [31:0]        r_uart_q;
    logic [1:0]         r_stat_q;
    logic [SEG_W-1:0]   w_seg_mask, w_seg_next;
    logic [31:0]        w_seg_ext, w_timer_ext;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_seg_mask = '0;
        for (int b = 0; b < SEG_W; b++) w_seg_mask[b] = byteen[b/8];
        w_seg_next = (r_seg & ~w_seg_mask) | (writedata[SEG_W-1:0] & w_seg_mask);
        w_seg_ext  = '0;
        w_seg_ext[SEG_W-1:0] = r_seg;
        w_timer_ext = '0;
        w_timer_ext[TIMER_W-1:0] = r_timer_q;
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg     <= '0;
            r_timer   <= '0;
            r_timer_q <= '0;
            r_sel     <= SEL_RAM;
            r_uart_q  <= '0;
            r_stat_q  <= '0;
        end else begin
            r_timer <= (w_wr && w_is_timer) ? writedata[TIMER_W-1:0] : r_timer + 1'b1;
            if (w_wr && w_is_seg)
                r_seg <= w_seg_next;
            if (w_rd) begin
                r_timer_q <= r_timer;
                r_stat_q  <= {~tx_full, ~rx_empty};
                r_uart_q  <= rx_empty ? '1 : {24'h0, rx_data};
                if (w_is_seg)        r_sel <= SEL_SEG;
                else if (w_is_uart)  r_sel <= SEL_UART;
                else if (w_is_stat)  r_sel <= SEL_STAT;
                else if (w_is_timer) r_sel <= SEL_TIMER;
                else                 r_sel <= SEL_RAM;
            end
        end
    end

    assign seg_io = r_seg;

    always_comb begin
        readdata = r_ram_q;
        case (r_sel)
            SEL_SEG:   readdata = w_seg_ext;
            SEL_UART:  readdata = r_uart_q;
            SEL_STAT:  readdata = {30'h0, r_stat_q};
            SEL_TIMER: readdata = w_timer_ext;
            default:   readdata = r_ram_q;
        endcase
    end
endmodule

// File: tb/tb_memory_mmio.sv
// Bench for memory_mmio: a vector table driven through a load scoreboard, plus
// hand sequences for stalls, blocking RX, timer wrap and reset abort.
module tb_memory_mmio;
    localparam int RAM_AW = 10, SEG_W = 16, TIMER_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [31:0]       addr_inst, addr, writedata;
    logic [3:0]        byteen;
    logic              writectrl, readctrl, rx_empty, tx_full;
    logic [7:0]        rx_data;
    logic [31:0]       readdata_inst, readdata;
    logic              stall, rx_rdreq, tx_wrreq;
    logic [7:0]        tx_data;
    logic [SEG_W-1:0]  seg_io;

    logic              readctrl_b, writectrl_b;
    logic [31:0]       b_readdata_inst, b_readdata;
    logic              b_stall, b_rx_rdreq, b_tx_wrreq;
    logic [7:0]        b_tx_data;
    logic [SEG_W-1:0]  b_seg_io;

    memory_mmio #(.RAM_AW(RAM_AW), .SEG_W(SEG_W), .BLOCKING_RX(1'b0), .TIMER_W(TIMER_W)) dut (
        .clk(clk), .reset(reset), .addr_inst(addr_inst), .readdata_inst(readdata_inst),
        .addr(addr), .writedata(writedata), .byteen(byteen), .writectrl(writectrl),
        .readctrl(readctrl), .readdata(readdata), .stall(stall), .rx_empty(rx_empty),
        .rx_data(rx_data), .rx_rdreq(rx_rdreq), .tx_full(tx_full), .tx_data(tx_data),
        .tx_wrreq(tx_wrreq), .seg_io(seg_io));

    memory_mmio #(.RAM_AW(RAM_AW), .SEG_W(SEG_W), .BLOCKING_RX(1'b1), .TIMER_W(TIMER_W)) dut_b (
        .clk(clk), .reset(reset), .addr_inst(addr_inst), .readdata_inst(b_readdata_inst),
        .addr(addr), .writedata(writedata), .byteen(byteen), .writectrl(writectrl_b),
        .readctrl(readctrl_b), .readdata(b_readdata), .stall(b_stall), .rx_empty(rx_empty),
        .rx_data(rx_data), .rx_rdreq(b_rx_rdreq), .tx_full(tx_full), .tx_data(b_tx_data),
        .tx_wrreq(b_tx_wrreq), .seg_io(b_seg_io));

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
        int          id;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        rd, wr;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        rxe;
        logic [7:0]  rxd;
        logic        txf;
        logic [31:0] exp_rd;
        logic        exp_stall, exp_rdreq, exp_wrreq;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input logic rxe,
                                input logic [7:0] rxd, input logic txf, input logic [31:0] exp_rd,
                                input logic st, input logic rq, input logic wq);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.be = be;
        v.rxe = rxe; v.rxd = rxd; v.txf = txf; v.exp_rd = exp_rd;
        v.exp_stall = st; v.exp_rdreq = rq; v.exp_wrreq = wq;
        return v;
    endfunction

    task automatic sb_check();
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check($sformatf("load#%0d readdata", e.id), readdata, e.data);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sb_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        readctrl = rd; writectrl = wr; addr = a; writedata = wd; byteen = be;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    endtask

    int load_id = 0;
    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        drive(1'b1, 1'b0, a, 32'h0, 4'h0);
        e.data = exp; e.due = cyc + 1; e.id = load_id++;
        sb_q.push_back(e);
        to_neg();
        to_pos();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; addr_inst = 32'h0; rx_data = 8'h0;
        writectrl_b = 1'b0; readctrl_b = 1'b1;
        rx_empty = 1'b0; tx_full = 1'b0;
        drive(1'b0, 1'b1, 32'h4, 32'h41, 4'hF);

        // Handshakes and stall must stay low while reset is held.
        to_neg();
        check("reset tx_wrreq", {31'h0, tx_wrreq}, 32'h0);
        check("reset b rx_rdreq", {31'h0, b_rx_rdreq}, 32'h0);
        to_pos();
        tx_full = 1'b1; rx_empty = 1'b1;
        to_neg();
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset b stall", {31'h0, b_stall}, 32'h0);
        to_pos();
        reset = 1'b0; readctrl_b = 1'b0; tx_full = 1'b0;
        idle();
        check("reset seg_io", {16'h0, seg_io}, 32'h0);
        load(32'hC, 32'h0);

        vecs.push_back(mk(0,1,32'h100,      32'hDEADBEEF,4'hF,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(0,1,32'h100,      32'h00001100,4'h2,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h100,      32'h0,       4'h0,1,8'h00,0,32'hDEAD11EF,0,0,0));
        vecs.push_back(mk(0,1,32'h104,      32'hCAFEF00D,4'hF,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(0,1,32'h104,      32'hFFFFFFFF,4'h0,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h104,      32'h0,       4'h0,1,8'h00,0,32'hCAFEF00D,0,0,0));
        vecs.push_back(mk(0,1,32'h10000108, 32'h13579BDF,4'hF,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h108,      32'h0,       4'h0,1,8'h00,0,32'h13579BDF,0,0,0));
        vecs.push_back(mk(0,1,32'h0,        32'h00001234,4'h1,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h0,        32'h0,       4'h0,1,8'h00,0,32'h00000034,0,0,0));
        vecs.push_back(mk(0,1,32'h0,        32'hABCDEF56,4'hE,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h0,        32'h0,       4'h0,1,8'h00,0,32'h0000EF34,0,0,0));
        vecs.push_back(mk(0,1,32'h10000008, 32'h11112222,4'hF,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(0,1,32'h8,        32'h99999999,4'hF,1,8'h00,0,32'h0,       0,0,0));
        vecs.push_back(mk(1,0,32'h10000008, 32'h0,       4'h0,1,8'h00,0,32'h11112222,0,0,0));
        vecs.push_back(mk(1,0,32'h0,        32'h0,       4'h0,1,8'h00,0,32'h0000EF34,0,0,0));
        vecs.push_back(mk(1,0,32'h8,        32'h0,       4'h0,0,8'h00,1,32'h00000001,0,0,0));
        vecs.push_back(mk(1,0,32'h8,        32'h0,       4'h0,1,8'h00,0,32'h00000002,0,0,0));
        vecs.push_back(mk(1,0,32'h4,        32'h0,       4'h0,1,8'h00,0,32'hFFFFFFFF,0,0,0));
        vecs.push_back(mk(1,0,32'h4,        32'h0,       4'h0,0,8'hA5,0,32'h000000A5,0,1,0));
        vecs.push_back(mk(0,1,32'h4,        32'h00000041,4'hF,1,8'h00,0,32'h0,       0,0,1));
        vecs.push_back(mk(0,1,32'h4,        32'h00000042,4'h0,1,8'h00,0,32'h0,       0,0,1));
        vecs.push_back(mk(0,0,32'h200,      32'h0,       4'h0,1,8'h00,0,32'h0,       0,0,0));

        foreach (vecs[k]) begin
            drive(vecs[k].rd, vecs[k].wr, vecs[k].a, vecs[k].wd, vecs[k].be);
            rx_empty = vecs[k].rxe; rx_data = vecs[k].rxd; tx_full = vecs[k].txf;
            if (vecs[k].rd && !vecs[k].wr) begin
                e.data = vecs[k].exp_rd; e.due = cyc + 1; e.id = load_id++;
                sb_q.push_back(e);
            end
            to_neg();
            check($sformatf("vec%0d stall", k), {31'h0, stall}, {31'h0, vecs[k].exp_stall});
            check($sformatf("vec%0d rx_rdreq", k), {31'h0, rx_rdreq}, {31'h0, vecs[k].exp_rdreq});
            check($sformatf("vec%0d tx_wrreq", k), {31'h0, tx_wrreq}, {31'h0, vecs[k].exp_wrreq});
            to_pos();
        end
        rx_empty = 1'b1; tx_full = 1'b0;
        check("seg_io after table", {16'h0, seg_io}, 32'h0000EF34);

        // Fetch port: plain read, then read-during-write returns old data.
        addr_inst = 32'h100; idle();
        to_neg(); to_pos();
        drive(1'b0, 1'b1, 32'h100, 32'h01020304, 4'hF);
        to_neg();
        check("fetch 0x100", readdata_inst, 32'hDEAD11EF);
        to_pos();
        idle();
        to_neg();
        check("fetch old on collision", readdata_inst, 32'hDEAD11EF);
        to_pos();
        to_neg();
        check("fetch new data", readdata_inst, 32'h01020304);
        to_pos();
        load(32'h100, 32'h01020304);

        // TX back-pressure: held stall, then release in the same cycle.
        tx_full = 1'b1;
        drive(1'b0, 1'b1, 32'h4, 32'h00000041, 4'hF);
        for (int c = 0; c < 3; c++) begin
            to_neg();
            check($sformatf("tx stall c%0d", c), {31'h0, stall}, 32'h1);
            check($sformatf("tx held c%0d", c), {31'h0, tx_wrreq}, 32'h0);
            to_pos();
        end
        tx_full = 1'b0;
        to_neg();
        check("tx release stall", {31'h0, stall}, 32'h0);
        check("tx release wrreq", {31'h0, tx_wrreq}, 32'h1);
        check("tx release data", {24'h0, tx_data}, 32'h41);
        to_pos();
        idle();

        // Blocking RX variant: stall until data arrives, single pop, captured byte.
        addr = 32'h4; readctrl_b = 1'b1; rx_empty = 1'b1;
        for (int c = 0; c < 3; c++) begin
            to_neg();
            check($sformatf("rx block stall c%0d", c), {31'h0, b_stall}, 32'h1);
            check($sformatf("rx block rdreq c%0d", c), {31'h0, b_rx_rdreq}, 32'h0);
            to_pos();
        end
        rx_empty = 1'b0; rx_data = 8'h5A;
        to_neg();
        check("rx unblock stall", {31'h0, b_stall}, 32'h0);
        check("rx unblock rdreq", {31'h0, b_rx_rdreq}, 32'h1);
        to_pos();
        readctrl_b = 1'b0; rx_data = 8'h77;
        to_neg();
        check("rx single pop", {31'h0, b_rx_rdreq}, 32'h0);
        check("rx captured data", b_readdata, 32'h0000005A);
        to_pos();
        rx_empty = 1'b1; idle();

        // Timer: load ignores byteen, then wraps 0xF -> 0x0.
        drive(1'b0, 1'b1, 32'hC, 32'h0000000E, 4'h0);
        to_neg(); to_pos();
        load(32'hC, 32'hE);
        load(32'hC, 32'hF);
        load(32'hC, 32'h0);
        idle();
        reset = 1'b1;
        to_neg(); to_pos();
        reset = 1'b0;
        load(32'hC, 32'h0);
        load(32'hC, 32'h1);
        idle();
        to_neg(); to_pos();

        // Reset aborts a stalled TX write and clears seg_io.
        drive(1'b0, 1'b1, 32'h0, 32'h00001234, 4'h1);
        to_neg(); to_pos();
        check("seg_io byte0 store", {16'h0, seg_io}, 32'h00000034);
        tx_full = 1'b1;
        drive(1'b0, 1'b1, 32'h4, 32'h00000055, 4'hF);
        to_neg();
        check("pre-reset stall", {31'h0, stall}, 32'h1);
        to_pos();
        reset = 1'b1;
        to_neg();
        check("reset abort stall", {31'h0, stall}, 32'h0);
        check("reset abort wrreq", {31'h0, tx_wrreq}, 32'h0);
        to_pos();
        reset = 1'b0; tx_full = 1'b0; idle();
        to_neg();
        check("reset abort seg_io", {16'h0, seg_io}, 32'h0);
        check("dropped write no push", {31'h0, tx_wrreq}, 32'h0);
        to_pos();
        to_neg();

        check("scoreboard drained", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
